// File: rtl/norm_lzc_pipe_pkg.sv
// norm_lzc_pipe_pkg: shared widths, shift table and stage payload for the normalizer
package norm_lzc_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int EXP_W = 8;
  localparam int LZC_W = 6;
  localparam int N_SHIFT = 5;
  localparam int SHIFT_TAB [N_SHIFT] = '{16, 8, 4, 2, 1};
  typedef struct packed {
    logic valid;
    logic [DATA_W-1:0] data;
    logic [LZC_W-1:0] lzc;
    logic [EXP_W-1:0] exp;
    logic byp;
    logic zero;
    logic ovf;
    logic sticky;
  } stage_t;
endpackage

// File: rtl/norm_lzc_pipe_if.sv
// norm_lzc_pipe_if: input word and normalized result bundle with pipeline enable
interface norm_lzc_pipe_if;
  import norm_lzc_pipe_pkg::*;
  logic en;
  logic in_valid;
  logic [DATA_W-1:0] in_sum;
  logic in_cout;
  logic [EXP_W-1:0] in_exp;
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  logic [LZC_W-1:0] out_lzc;
  logic [EXP_W-1:0] out_exp;
  logic out_zero;
  logic out_ovf;
  logic out_unf;
  logic out_sticky;
  modport master (output en, in_valid, in_sum, in_cout, in_exp,
                  input out_valid, out_data, out_lzc, out_exp, out_zero, out_ovf, out_unf, out_sticky);
  modport slave (input en, in_valid, in_sum, in_cout, in_exp,
                 output out_valid, out_data, out_lzc, out_exp, out_zero, out_ovf, out_unf, out_sticky);
endinterface

// File: rtl/norm_shift_stage.sv
// norm_shift_stage: registered conditional left shift by n with leading-zero accumulate
module norm_shift_stage
  import norm_lzc_pipe_pkg::*;
#(
  parameter int n = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   byp,
  input  stage_t d,
  output stage_t q
);
  logic   hit;
  stage_t nx;
  assign hit = !byp && d.data[DATA_W-1 -: n] == '0;
  // shift only when the top n bits are all zero
  always_comb begin
    nx = d;
    nx.data = hit ? d.data << n : d.data;
    nx.lzc = hit ? d.lzc + LZC_W'(n) : d.lzc;
  end
  // stage register, frozen while en is low
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= nx;
endmodule

// File: rtl/norm_lzc_pipe.sv
// norm_lzc_pipe: 6-stage carry-handling and leading-zero normalizer for adder sums
module norm_lzc_pipe
  import norm_lzc_pipe_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int EW = EXP_W
) (
  input logic clk,
  input logic rst,
  norm_lzc_pipe_if.slave bus
);
  stage_t [N_SHIFT:0] st;
  stage_t nx0;
  stage_t f;
  logic sat;
  logic unf;
  assign sat = bus.in_cout && &bus.in_exp;
  // carry-out folds into the mantissa with a right shift; carry and zero words skip the shifters
  always_comb begin
    nx0.valid = bus.in_valid;
    nx0.data = bus.in_cout ? {1'b1, bus.in_sum[W-1:1]} : bus.in_sum;
    nx0.lzc = '0;
    nx0.exp = bus.in_cout ? (sat ? '1 : bus.in_exp + EW'(1)) : bus.in_exp;
    nx0.zero = !bus.in_cout && bus.in_sum == '0;
    nx0.byp = bus.in_cout || bus.in_sum == '0;
    nx0.ovf = sat;
    nx0.sticky = bus.in_cout && bus.in_sum[0];
  end
  // S0 register
  always_ff @(posedge clk or posedge rst)
    if (rst) st[0] <= '0;
    else if (bus.en) st[0] <= nx0;
  for (genvar i = 0; i < N_SHIFT; i++) begin : g_sh
    norm_shift_stage #(.n(SHIFT_TAB[i])) u_stage (
      .clk(clk), .rst(rst), .en(bus.en), .byp(st[i].byp), .d(st[i]), .q(st[i+1])
    );
  end
  assign f = st[N_SHIFT];
  assign unf = !f.zero && EW'(f.lzc) > f.exp;
  assign bus.out_valid = f.valid;
  assign bus.out_data = f.data;
  assign bus.out_lzc = f.zero ? LZC_W'(W) : f.lzc;
  assign bus.out_exp = (f.zero || unf) ? '0 : f.exp - EW'(f.lzc);
  assign bus.out_zero = f.zero;
  assign bus.out_ovf = f.ovf;
  assign bus.out_unf = unf;
  assign bus.out_sticky = f.sticky;
endmodule

// File: tb/tb_norm_lzc_pipe.sv
// tb_norm_lzc_pipe: directed and randomized check of the normalizer against a reference model
module tb_norm_lzc_pipe;
  typedef struct {
    logic [31:0] data;
    logic [5:0] lzc;
    logic [7:0] exp;
    logic zero, ovf, unf, sticky;
    int due;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int compared = 0;
  int mismatched = 0;
  int ecnt = 0;
  exp_t q[$];
  norm_lzc_pipe_if bus ();
  norm_lzc_pipe #(.W(32), .EW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] s, input logic c, input logic [7:0] e);
    exp_t r;
    int lz;
    int x;
    r = '{data: 0, lzc: 0, exp: 0, zero: 0, ovf: 0, unf: 0, sticky: 0, due: 0};
    if (c) begin
      r.data = (s >> 1) | 32'h8000_0000;
      r.ovf = (e == 8'd255);
      r.exp = r.ovf ? 8'd255 : e + 8'd1;
      r.sticky = s[0];
    end else if (s == 0) begin
      r.zero = 1;
      r.lzc = 6'd32;
    end else begin
      lz = 0;
      while (!s[31-lz]) lz++;
      r.data = s << lz;
      r.lzc = 6'(lz);
      x = int'(e) - lz;
      r.unf = (x < 0);
      r.exp = r.unf ? 8'd0 : 8'(x);
    end
    return r;
  endfunction

  function automatic logic [63:0] outs();
    return {13'd0, bus.out_valid, bus.out_data, bus.out_lzc, bus.out_exp,
            bus.out_zero, bus.out_ovf, bus.out_unf, bus.out_sticky};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_out();
    logic expv;
    exp_t r;
    expv = q.size() > 0 && q[0].due == ecnt;
    chk("out_valid", 64'(bus.out_valid), 64'(expv));
    if (expv) begin
      r = q.pop_front();
      chk("out_data", 64'(bus.out_data), 64'(r.data));
      chk("out_lzc", 64'(bus.out_lzc), 64'(r.lzc));
      chk("out_exp", 64'(bus.out_exp), 64'(r.exp));
      chk("out_flags", 64'({bus.out_zero, bus.out_ovf, bus.out_unf, bus.out_sticky}),
          64'({r.zero, r.ovf, r.unf, r.sticky}));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] s, input logic c, input logic [7:0] e, input logic g);
    logic [63:0] snap;
    exp_t r;
    bus.in_valid = v;
    bus.in_sum = s;
    bus.in_cout = c;
    bus.in_exp = e;
    bus.en = g;
    snap = outs();
    @(posedge clk);
    #1;
    if (g) begin
      ecnt++;
      if (v) begin
        r = model(s, c, e);
        r.due = ecnt + 5;
        q.push_back(r);
      end
      check_out();
    end else chk("hold", outs(), snap);
  endtask

  task automatic bubbles(input int k);
    for (int i = 0; i < k; i++) step(0, 32'hDEAD_BEEF, 0, 8'h55, 1);
  endtask

  logic [31:0] ws [8];
  logic [31:0] rs;
  int k;

  initial begin
    bus.en = 1;
    bus.in_valid = 1;
    bus.in_sum = 32'h1234;
    bus.in_cout = 0;
    bus.in_exp = 8'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 64'd0);
    rst = 0;
    bus.in_valid = 0;
    step(1, 32'h0000_0001, 0, 8'd40, 1);
    step(1, 32'h0000_0000, 0, 8'd100, 1);
    step(1, 32'h0000_0003, 1, 8'hFF, 1);
    step(1, 32'h0001_0000, 0, 8'd5, 1);
    step(1, 32'h0000_0100, 0, 8'd23, 1);
    step(1, 32'h8000_0000, 0, 8'd0, 1);
    bubbles(6);
    for (int i = 0; i < 8; i++) ws[i] = $urandom >> $urandom_range(0, 31);
    k = 0;
    for (int c = 1; k < 8 && c < 20; c++) begin
      step(1, ws[k], 1'(k == 5), 8'(k * 7 + 3), !(c == 3 || c == 4));
      if (!(c == 3 || c == 4)) k++;
    end
    bubbles(7);
    chk("stream_drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < 4; i++) step(1, 32'h0000_00F0 << i, 0, 8'd60, 1);
    rst = 1;
    #2;
    chk("rst_async_outs", outs(), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_outs", outs(), 64'd0);
    rst = 0;
    bubbles(7);
    step(1, 32'h0000_0040, 0, 8'd30, 1);
    bubbles(3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    bubbles(4);
    chk("post_rst_drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      step($urandom_range(0, 9) < 7, rs, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom), $urandom_range(0, 4) != 0);
    end
    bubbles(7);
    chk("final_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
